// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: carries the decode control bundle and operands into EX one cycle later,
// with stall hold, bubble injection and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              ALUSrc_i,
  input  logic              Branch_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [9:0]        funct_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [DATA_W-1:0] PC_i,
  input  logic [4:0]        RS1addr_i,
  input  logic [4:0]        RS2addr_i,
  input  logic [4:0]        RDaddr_i,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              ALUSrc_o,
  output logic              Branch_o,
  output logic [1:0]        ALUOp_o,
  output logic [9:0]        funct_o,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] Imm_o,
  output logic [DATA_W-1:0] PC_o,
  output logic [4:0]        RS1addr_o,
  output logic [4:0]        RS2addr_o,
  output logic [4:0]        RDaddr_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Edge priority: rst_i > flush_i > stall_i > load. A bubble enters EX on a flush,
  // or on a load of an invalid decode slot.
  logic bubbleEdge;
  assign bubbleEdge = !rst_i && (flush_i || (!stall_i && !valid_i));

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_o    <= 1'b0;
      RegWrite_o <= 1'b0;
      MemtoReg_o <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
      ALUSrc_o   <= 1'b0;
      Branch_o   <= 1'b0;
      ALUOp_o    <= 2'b00;
      funct_o    <= '0;
      RS1data_o  <= '0;
      RS2data_o  <= '0;
      Imm_o      <= '0;
      PC_o       <= '0;
      RS1addr_o  <= '0;
      RS2addr_o  <= '0;
      RDaddr_o   <= '0;
    end else if (!stall_i) begin
      // Control is gated by valid_i; data still flows so forwarding sees defined values.
      valid_o    <= valid_i;
      RegWrite_o <= valid_i & RegWrite_i;
      MemtoReg_o <= valid_i & MemtoReg_i;
      MemRead_o  <= valid_i & MemRead_i;
      MemWrite_o <= valid_i & MemWrite_i;
      ALUSrc_o   <= valid_i & ALUSrc_i;
      Branch_o   <= valid_i & Branch_i;
      ALUOp_o    <= valid_i ? ALUOp_i : 2'b00;
      funct_o    <= funct_i;
      RS1data_o  <= RS1data_i;
      RS2data_o  <= RS2data_i;
      Imm_o      <= Imm_i;
      PC_o       <= PC_i;
      RS1addr_o  <= RS1addr_i;
      RS2addr_o  <= RS2addr_i;
      RDaddr_o   <= RDaddr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
    end else if (bubbleEdge && (bubble_cnt_o != {CNT_W{1'b1}})) begin
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (counter built 4 bits wide to reach saturation).
module tb_id_ex_pipe_reg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i, stall_i, flush_i, valid_i;
  logic              RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i;
  logic [1:0]        ALUOp_i;
  logic [9:0]        funct_i;
  logic [DATA_W-1:0] RS1data_i, RS2data_i, Imm_i, PC_i;
  logic [4:0]        RS1addr_i, RS2addr_i, RDaddr_i;
  logic              valid_o;
  logic              RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o;
  logic [1:0]        ALUOp_o;
  logic [9:0]        funct_o;
  logic [DATA_W-1:0] RS1data_o, RS2data_o, Imm_o, PC_o;
  logic [4:0]        RS1addr_o, RS2addr_o, RDaddr_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  int total = 0;
  int bad   = 0;
  int expCnt = 0;

  always #5 clk_i = ~clk_i;

  id_ex_pipe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .Branch_i(Branch_i),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .PC_i(PC_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .valid_o(valid_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o),
    .ALUOp_o(ALUOp_o), .funct_o(funct_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .PC_o(PC_o),
    .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic randInputs();
    valid_i    = 1'($urandom_range(0, 1));
    RegWrite_i = 1'($urandom_range(0, 1));
    MemtoReg_i = 1'($urandom_range(0, 1));
    MemRead_i  = 1'($urandom_range(0, 1));
    MemWrite_i = 1'($urandom_range(0, 1));
    ALUSrc_i   = 1'($urandom_range(0, 1));
    Branch_i   = 1'($urandom_range(0, 1));
    ALUOp_i    = 2'($urandom_range(0, 3));
    funct_i    = 10'($urandom_range(0, 1023));
    RS1data_i  = $urandom;
    RS2data_i  = $urandom;
    Imm_i      = $urandom;
    PC_i       = $urandom;
    RS1addr_i  = 5'($urandom_range(0, 31));
    RS2addr_i  = 5'($urandom_range(0, 31));
    RDaddr_i   = 5'($urandom_range(0, 31));
  endtask

  task automatic clearCtrl();
    valid_i = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0; MemRead_i = 1'b0;
    MemWrite_i = 1'b0; ALUSrc_i = 1'b0; Branch_i = 1'b0; ALUOp_i = 2'b00;
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_ctrl"}, {valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
                             ALUSrc_o, Branch_o, ALUOp_o}, 64'd0);
    checkVal({tag, "_funct"}, funct_o, 64'd0);
    checkVal({tag, "_rsdata"}, {RS1data_o, RS2data_o}, 64'd0);
    checkVal({tag, "_immpc"}, {Imm_o, PC_o}, 64'd0);
    checkVal({tag, "_addr"}, {RS1addr_o, RS2addr_o, RDaddr_o}, 64'd0);
    checkVal({tag, "_cnt"}, bubble_cnt_o, 64'd0);
  endtask

  initial begin
    stall_i = 1'b0; flush_i = 1'b0; rst_i = 1'b1;
    randInputs();
    // Reset with random inputs for two edges
    tick();
    randInputs(); stall_i = 1'b1;
    tick();
    checkAllZero("reset");
    expCnt = 0;

    // First load after reset release, latency one cycle
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    randInputs(); clearCtrl();
    valid_i = 1'b1; RegWrite_i = 1'b1; ALUOp_i = 2'b01; RS1data_i = 32'h0000_0005; RDaddr_i = 5'd7;
    #2;
    checkVal("pre_edge_valid", valid_o, 64'd0);
    tick();
    checkVal("load_valid", valid_o, 64'd1);
    checkVal("load_regwrite", RegWrite_o, 64'd1);
    checkVal("load_aluop", ALUOp_o, 64'd1);
    checkVal("load_rs1data", RS1data_o, 64'd5);
    checkVal("load_rdaddr", RDaddr_o, 64'd7);
    checkVal("load_cnt", bubble_cnt_o, expCnt);

    // Full-field load
    clearCtrl();
    valid_i = 1'b1; MemtoReg_i = 1'b1; MemRead_i = 1'b1; ALUSrc_i = 1'b1; ALUOp_i = 2'b10;
    funct_i = 10'h2A5; RS1data_i = 32'h1234_5678; RS2data_i = 32'h9ABC_DEF0;
    Imm_i = 32'h0000_0800; PC_i = 32'h0000_1004;
    RS1addr_i = 5'd1; RS2addr_i = 5'd31; RDaddr_i = 5'd17;
    tick();
    checkVal("full_ctrl", {valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
                           ALUSrc_o, Branch_o, ALUOp_o}, 64'b1_0110_10_10);
    checkVal("full_funct", funct_o, 64'h2A5);
    checkVal("full_rsdata", {RS1data_o, RS2data_o}, 64'h1234_5678_9ABC_DEF0);
    checkVal("full_immpc", {Imm_o, PC_o}, 64'h0000_0800_0000_1004);
    checkVal("full_addr", {RS1addr_o, RS2addr_o, RDaddr_o}, {49'd0, 5'd1, 5'd31, 5'd17});

    // Load a store, then stall three cycles with changing inputs
    clearCtrl();
    valid_i = 1'b1; MemWrite_i = 1'b1; Imm_i = 32'hFFFF_FFFC; ALUSrc_i = 1'b1;
    tick();
    checkVal("store_memwrite", MemWrite_o, 64'd1);
    checkVal("store_imm", Imm_o, 64'hFFFF_FFFC);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randInputs(); MemWrite_i = 1'b0; Imm_i = 32'h0000_0010 + 32'(i);
      tick();
      checkVal($sformatf("stall%0d_memwrite", i), MemWrite_o, 64'd1);
      checkVal($sformatf("stall%0d_imm", i), Imm_o, 64'hFFFF_FFFC);
      checkVal($sformatf("stall%0d_valid", i), valid_o, 64'd1);
      checkVal($sformatf("stall%0d_cnt", i), bubble_cnt_o, expCnt);
    end

    // Stall of a bubble must not count
    stall_i = 1'b1; valid_i = 1'b0;
    tick();
    checkVal("stall_invalid_cnt", bubble_cnt_o, expCnt);

    // Flush beats stall
    stall_i = 1'b1; flush_i = 1'b1;
    clearCtrl(); valid_i = 1'b1; Branch_i = 1'b1; PC_i = 32'h0000_0100;
    tick();
    expCnt = 1;
    checkVal("flush_valid", valid_o, 64'd0);
    checkVal("flush_branch", Branch_o, 64'd0);
    checkVal("flush_pc", PC_o, 64'd0);
    checkVal("flush_cnt", bubble_cnt_o, expCnt);

    // Invalid decode: control forced off, data still copied
    stall_i = 1'b0; flush_i = 1'b0;
    randInputs(); valid_i = 1'b0; RegWrite_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b1;
    Branch_i = 1'b1; RS2addr_i = 5'd3; RS1data_i = 32'h0000_ABCD;
    tick();
    expCnt = 2;
    checkVal("bubble_ctrl", {valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
                             ALUSrc_o, Branch_o, ALUOp_o}, 64'd0);
    checkVal("bubble_rs2addr", RS2addr_o, 64'd3);
    checkVal("bubble_rs1data", RS1data_o, 64'h0000_ABCD);
    checkVal("bubble_cnt", bubble_cnt_o, expCnt);

    // Reset mid-operation wins over stall and flush, and is not counted
    rst_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1; randInputs();
    tick();
    checkAllZero("midreset");
    expCnt = 0;

    // Twenty consecutive flushes saturate the 4-bit counter at 15
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      randInputs();
      tick();
      if (expCnt < 15) expCnt++;
      checkVal($sformatf("sat%0d_cnt", i), bubble_cnt_o, expCnt);
    end
    checkVal("sat_final", bubble_cnt_o, 64'd15);

    flush_i = 1'b0; rst_i = 1'b1;
    tick();
    checkVal("sat_reset_cnt", bubble_cnt_o, 64'd0);
    rst_i = 1'b0; stall_i = 1'b1;
    tick();
    checkVal("post_reset_hold_cnt", bubble_cnt_o, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core.
- Captures the decode-stage control bundle (RegWrite/MemtoReg/MemRead/MemWrite/ALUOp/ALUSrc/Branch) plus the register-file operands, immediate, funct bits, register addresses and PC, and presents them to EX one cycle later.
- Supports hold (stall), bubble injection (flush / invalid decode) and a saturating bubble counter for performance statistics.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields
- CNT_W, 16, width of the bubble counter

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous reset, active-high
- stall_i  in  1  hold all stage contents this cycle
- flush_i  in  1  replace the stage contents with a bubble
- valid_i  in  1  decode slot holds a real instruction (0 = NoOp)
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i  in  1 each  control from decode
- ALUOp_i  in  2  ALU op class from decode
- funct_i  in  10  {funct7, funct3}
- RS1data_i, RS2data_i, Imm_i, PC_i  in  DATA_W each  operands, sign-extended immediate, instruction PC
- RS1addr_i, RS2addr_i, RDaddr_i  in  5 each  register indices
- valid_o  out  1  EX slot holds a real instruction
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o  out  1 each  registered control
- ALUOp_o  out  2  registered ALUOp
- funct_o  out  10  registered funct
- RS1data_o, RS2data_o, Imm_o, PC_o  out  DATA_W each  registered data
- RS1addr_o, RS2addr_o, RDaddr_o  out  5 each  registered indices
- bubble_cnt_o  out  CNT_W  count of bubbles entered into EX

Behaviour:
- All outputs are registered: no combinational path from any input to any output. Latency is 1 cycle.
- Per-edge priority: rst_i > flush_i > stall_i > load.
- Reset (rst_i=1 at the edge):
  - every output, including bubble_cnt_o, becomes 0;
  - applies mid-operation regardless of stall_i/flush_i.
- Flush (flush_i=1):
  - valid_o=0, all seven control outputs 0;
  - funct_o, data, address and PC outputs 0.
  - Flush wins over a simultaneous stall_i=1.
- Stall (stall_i=1, flush_i=0):
  - every output, including valid_o, holds its value;
  - bubble_cnt_o does not change.
- Load (stall_i=0, flush_i=0):
  - valid_i=1: all fields copied from inputs; valid_o=1.
  - valid_i=0 (bubble): valid_o=0 and the seven control outputs are forced to 0 regardless of the control inputs. Data, address, funct and PC fields are still copied, so the forwarding unit sees defined values.
- A bubble is any flush edge, or any load edge with valid_i=0.
  - A bubble edge increments bubble_cnt_o by 1.
  - bubble_cnt_o saturates at 2^CNT_W-1 and does not wrap.
  - A reset edge clears the counter; the reset edge itself is not counted.
- Invariant: valid_o=0 implies RegWrite_o=MemWrite_o=MemRead_o=Branch_o=0.
- ALUOp widths are fixed at 2 bits. All other fields are straight width-preserving copies with no arithmetic.

Test Plan:
- Reset: drive random inputs with rst_i=1 for 2 cycles -> all outputs 0 and bubble_cnt_o=0; first load after release appears exactly 1 cycle later.
- Load: valid_i=1, RegWrite_i=1, ALUOp_i=2'b01, RS1data_i=32'h0000_0005, RDaddr_i=5'd7 -> next cycle valid_o=1, RegWrite_o=1, ALUOp_o=2'b01, RS1data_o=5, RDaddr_o=7; bubble_cnt_o unchanged.
- Stall: load a store (MemWrite_i=1, Imm_i=32'hFFFF_FFFC), then stall_i=1 for 3 cycles while the inputs change -> outputs hold MemWrite_o=1, Imm_o=32'hFFFF_FFFC for all 3 cycles.
- Flush over stall: stall_i=1 and flush_i=1 together with valid branch inputs -> next cycle valid_o=0, Branch_o=0, PC_o=0; bubble_cnt_o increments by 1.
- Invalid decode: valid_i=0, RegWrite_i=1, MemRead_i=1, RS2addr_i=5'd3 -> valid_o=0, RegWrite_o=0, MemRead_o=0, RS2addr_o=3; bubble_cnt_o increments by 1.
- Saturation, with CNT_W=4: 20 consecutive flushes -> bubble_cnt_o stops at 15; a subsequent rst_i pulse gives 0.
